ring_decoder: RTL
=================

# ring_decoder

Receive-side companion to the one-hot ring counter. Samples a WIDTH-bit one-hot ring code, decodes it to a binary position, and checks that successive samples follow the right-shift rotation (1000→0100→0010→0001→1000 for WIDTH=4). It acquires lock with a hunt/lock state machine and reports one-hot violations, sequence violations, completed laps and an error count. It sits directly downstream of any ring counter output, e.g. as a bench-side or in-system health monitor.

## Interface
- WIDTH, 4, ring width in bits; ≥2
- LOCK_CNT, 2, consecutive correct transitions required to enter LOCKED; ≥1
- LAP_W, 16, lap counter width
- ERR_W, 8, error counter width
- IW = $clog2(WIDTH), derived, not overridable

Ports:
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  reset, synchronous, active-low
- in_valid  in  1  ring_in is sampled on this edge
- ring_in  in  WIDTH  one-hot ring code, MSB = position 0
- idx  out  IW  decoded position of last valid one-hot sample
- idx_valid  out  1  one-cycle pulse: idx updated
- onehot_err  out  1  one-cycle pulse: sampled code not one-hot
- seq_err  out  1  one-cycle pulse: one-hot but not expected successor
- locked  out  1  state == LOCKED
- lap_cnt  out  LAP_W  completed laps while locked, wraps modulo 2^LAP_W
- err_cnt  out  ERR_W  onehot_err + seq_err events, saturates at all-ones

## Operation
- Decode: ring_in bit WIDTH-1 → idx 0, bit WIDTH-2 → 1, …, bit 0 → WIDTH-1. One-hot = exactly one bit set; all-zero and multi-hot are invalid.
- Internal: ref_idx (IW), ref_ok (1), good_run (width to hold LOCK_CNT), state {HUNT, LOCKED}.
- expected = (ref_idx == WIDTH-1) ? 0 : ref_idx+1 (explicit wrap; no reliance on power-of-two WIDTH).
- in_valid=0: all state and counters hold; all pulse outputs 0.
- in_valid=1, code invalid (any state): onehot_err=1, err_cnt+1 (sat), ref_ok←0, good_run←0, state←HUNT; idx holds, idx_valid=0.
- in_valid=1, code one-hot: idx←decoded, idx_valid=1, ref_idx←decoded, ref_ok←1; then:
  - HUNT, ref_ok=1 and decoded==expected: good_run+1; if good_run+1==LOCK_CNT → LOCKED, good_run←0.
  - HUNT, ref_ok=0: good_run←0, no error (first reference).
  - HUNT, ref_ok=1 and mismatch: good_run←0, no seq_err (errors not flagged during acquisition).
  - LOCKED, decoded==expected: stay; if ref_idx==WIDTH-1 and decoded==0 then lap_cnt+1.
  - LOCKED, mismatch (including repeat of same value): seq_err=1, err_cnt+1 (sat), state←HUNT, good_run←0; sample becomes new reference.
- Lap counting only in LOCKED; the transition that completes lock never counts a lap.

## Timing
- All outputs registered; response to a sample taken on edge N is visible after edge N (one-cycle latency from in_valid).
- Pulses (idx_valid, onehot_err, seq_err) high exactly one cycle per qualifying sample; back-to-back valid samples give back-to-back pulses.
- locked rises on the edge sampling the LOCK_CNT-th consecutive correct transition; falls on the edge sampling the first bad sample.
- Reset (rstn=0 at an edge) overrides in_valid: idx=0, idx_valid=0, onehot_err=0, seq_err=0, locked=0, lap_cnt=0, err_cnt=0, state=HUNT, ref_ok=0, good_run=0. Mid-stream reset discards lock; re-acquisition needs LOCK_CNT+1 samples.
- err_cnt at all-ones stays all-ones; pulses still fire.

## Test plan
- Reset: rstn=0 two cycles with in_valid=1, ring_in=1000 → all outputs zero, locked=0.
- Acquire (defaults): 1000,0100,0010 with in_valid=1 → idx 0,1,2, idx_valid each cycle, locked=1 after third sample, lap_cnt=0, err_cnt=0.
- Laps: continue 0001,1000 ×3 full rotations → lap_cnt=3, no errors.
- Sequence error: locked at idx 1 (0100), drive 0001 → seq_err pulse, err_cnt=1, locked=0, idx=3; then 1000,0100 → relocked, no lap counted for 0001→1000 in HUNT.
- One-hot error: locked, drive 0000 then 0110 → two onehot_err pulses, err_cnt=2, idx unchanged, locked=0; next 1000,0100,0010 relocks.
- Stall/saturation: in_valid=0 for 5 cycles → no change; with ERR_W=2 inject 5 invalid codes → err_cnt=3, onehot_err still pulses on each.

Source files
------------

// File: rtl/ring_decoder.sv
// One-hot ring code receiver: decodes position, tracks rotation,
// acquires lock and counts laps and errors.
module ring_decoder #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int LAP_W    = 16,
  parameter int ERR_W    = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         ring_in,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     idx_valid,
  output logic                     onehot_err,
  output logic                     seq_err,
  output logic                     locked,
  output logic [LAP_W-1:0]         lap_cnt,
  output logic [ERR_W-1:0]         err_cnt
);

  localparam int IW = $clog2(WIDTH);
  localparam int GW = $clog2(LOCK_CNT + 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   ref_idx, ref_idx_n;
  logic            ref_ok, ref_ok_n;
  logic [GW-1:0]   good_run, good_run_n;
  logic [IW-1:0]   idx_n;
  logic            idx_valid_n;
  logic            onehot_err_n;
  logic            seq_err_n;
  logic [LAP_W-1:0] lap_cnt_n;
  logic [ERR_W-1:0] err_cnt_n;

  logic            onehot;
  logic [IW-1:0]   dec;
  logic [IW-1:0]   exp_idx;
  logic            match;
  logic [ERR_W-1:0] err_inc;

  assign onehot = (ring_in != '0) &&
                  ((ring_in & (ring_in - WIDTH'(1))) == '0);

  always_comb begin
    dec = '0;
    for (int i = 0; i < WIDTH; i++)
      if (ring_in[i]) dec = IW'(WIDTH - 1 - i);
  end

  // explicit wrap so non-power-of-two widths rotate correctly
  assign exp_idx = (ref_idx == IW'(WIDTH - 1)) ? '0
                 : ref_idx + IW'(1);
  assign match   = ref_ok && (dec == exp_idx);
  assign err_inc = (err_cnt == '1) ? err_cnt
                 : err_cnt + ERR_W'(1);

  always_comb begin
    state_n      = state;
    ref_idx_n    = ref_idx;
    ref_ok_n     = ref_ok;
    good_run_n   = good_run;
    idx_n        = idx;
    idx_valid_n  = 1'b0;
    onehot_err_n = 1'b0;
    seq_err_n    = 1'b0;
    lap_cnt_n    = lap_cnt;
    err_cnt_n    = err_cnt;
    if (in_valid && !onehot) begin
      onehot_err_n = 1'b1;
      err_cnt_n    = err_inc;
      ref_ok_n     = 1'b0;
      good_run_n   = '0;
      state_n      = HUNT;
    end else if (in_valid) begin
      idx_n       = dec;
      idx_valid_n = 1'b1;
      ref_idx_n   = dec;
      ref_ok_n    = 1'b1;
      unique case (state)
        HUNT: begin
          if (match) begin
            if ((good_run + GW'(1)) == GW'(LOCK_CNT)) begin
              state_n    = LOCKED;
              good_run_n = '0;
            end else begin
              good_run_n = good_run + GW'(1);
            end
          end else begin
            good_run_n = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            if (ref_idx == IW'(WIDTH - 1))
              lap_cnt_n = lap_cnt + LAP_W'(1);
          end else begin
            seq_err_n  = 1'b1;
            err_cnt_n  = err_inc;
            state_n    = HUNT;
            good_run_n = '0;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= HUNT;
      ref_idx    <= '0;
      ref_ok     <= 1'b0;
      good_run   <= '0;
      idx        <= '0;
      idx_valid  <= 1'b0;
      onehot_err <= 1'b0;
      seq_err    <= 1'b0;
      lap_cnt    <= '0;
      err_cnt    <= '0;
    end else begin
      state      <= state_n;
      ref_idx    <= ref_idx_n;
      ref_ok     <= ref_ok_n;
      good_run   <= good_run_n;
      idx        <= idx_n;
      idx_valid  <= idx_valid_n;
      onehot_err <= onehot_err_n;
      seq_err    <= seq_err_n;
      lap_cnt    <= lap_cnt_n;
      err_cnt    <= err_cnt_n;
    end
  end

  assign locked = (state == LOCKED);

endmodule
